// File: rtl/my_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed display: walks digits 0..3 with a
// blanking gap before each dwell and latches display data once per frame.
//
// state | meaning
// IDLE  | scanner off, all digits blanked, waiting for en
// BLANK | inter-digit gap, all digits off for BLANK_CYCLES
// SHOW  | digit sel driven (lit unless masked) for DWELL_CYCLES
module my_scan_ctrl #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  digit_mask,
  input  logic [15:0] data_in,
  output logic [1:0]  sel,
  output logic        blank,
  output logic [3:0]  nibble,
  output logic        frame_tick
);

  localparam int DWELL_EFF = (DWELL_CYCLES < 1) ? 1 : DWELL_CYCLES;
  localparam int BLANK_EFF = (BLANK_CYCLES < 1) ? 1 : BLANK_CYCLES;
  localparam int MAX_EFF   = (DWELL_EFF > BLANK_EFF) ? DWELL_EFF : BLANK_EFF;
  localparam int CW        = $clog2(MAX_EFF + 1);

  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_EFF);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_EFF);
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [15:0]   shadow_data;
  logic [3:0]    shadow_mask;
  logic          last;

  // The counter is loaded with the phase length and the phase ends when it reads 1.
  assign last = (count == ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      shadow_data <= '0;
      shadow_mask <= '0;
      sel         <= 2'd0;
      blank       <= 1'b1;
      nibble      <= 4'd0;
      frame_tick  <= 1'b0;
    end else if (!en) begin
      state      <= IDLE;
      count      <= '0;
      sel        <= 2'd0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        IDLE: begin
          state       <= BLANK;
          count       <= BLANK_LOAD;
          shadow_data <= data_in;
          shadow_mask <= digit_mask;
          sel         <= 2'd0;
          blank       <= 1'b1;
        end
        BLANK: begin
          if (last) begin
            state  <= SHOW;
            count  <= DWELL_LOAD;
            nibble <= shadow_data[{sel, 2'b00} +: 4];
            blank  <= ~shadow_mask[sel];
          end else begin
            count <= count - ONE;
          end
        end
        SHOW: begin
          if (last) begin
            state <= BLANK;
            count <= BLANK_LOAD;
            blank <= 1'b1;
            sel   <= sel + 2'd1;
            // Frame boundary: new data only takes effect from digit 0 onward.
            if (sel == 2'd3) begin
              frame_tick  <= 1'b1;
              shadow_data <= data_in;
              shadow_mask <= digit_mask;
            end
          end else begin
            count <= count - ONE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          sel   <= 2'd0;
          blank <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_scan_ctrl.sv
// Bench for my_scan_ctrl: stimulus queues the hand-derived per-cycle output
// tuple, a monitor pops and compares it just after every rising edge.
module tb_my_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  digit_mask;
  logic [15:0] data_in;
  logic [1:0]  sel;
  logic        blank;
  logic [3:0]  nibble;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  my_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_mask (digit_mask),
    .data_in    (data_in),
    .sel        (sel),
    .blank      (blank),
    .nibble     (nibble),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Queue the outputs required after the next rising edge, then move one cycle on.
  task automatic step(input logic [1:0] s, input logic b, input logic [3:0] n, input logic ft);
    exp_q.push_back({s, b, n, ft});
    @(negedge clk);
  endtask

  // One digit slot: 2 blank cycles (old nibble held) then 4 dwell cycles.
  task automatic slot(input logic [1:0] s, input logic [3:0] pn, input logic [3:0] n,
                      input logic lit, input logic ft, input bit chg, input logic [15:0] nd);
    step(s, 1'b1, pn, ft);
    step(s, 1'b1, pn, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (chg && i == 2) data_in = nd;
      step(s, ~lit, n, 1'b0);
    end
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({sel, blank, nibble, frame_tick} !== e) begin
          failures++;
          $display("FAIL cycle_check t=%0t got sel=%0d blank=%0b nibble=%h tick=%0b required sel=%0d blank=%0b nibble=%h tick=%0b",
                   $time, sel, blank, nibble, frame_tick, e[7:6], e[5], e[4:1], e[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int wait_cycles;
    rst        = 1'b1;
    en         = 1'b1;
    digit_mask = 4'hF;
    data_in    = 16'h4321;
    @(negedge clk);

    // Reset held with en = 1.
    repeat (3) step(2'd0, 1'b1, 4'h0, 1'b0);
    rst = 1'b0;

    // Frame 1: plain timing, first digit lit two cycles after reset release.
    slot(2'd0, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0);
    slot(2'd1, 4'h1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0);
    slot(2'd2, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0, 16'h0);
    slot(2'd3, 4'h3, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0);

    // Frame 2: data changes mid digit 1 but the frame keeps its snapshot.
    slot(2'd0, 4'h4, 4'h1, 1'b1, 1'b1, 1'b0, 16'h0);
    slot(2'd1, 4'h1, 4'h2, 1'b1, 1'b0, 1'b1, 16'hABCD);
    slot(2'd2, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0, 16'h0);
    slot(2'd3, 4'h3, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0);

    // Frame 3: new data visible; mask changed mid-frame must not apply yet.
    slot(2'd0, 4'h4, 4'hD, 1'b1, 1'b1, 1'b0, 16'h0);
    slot(2'd1, 4'hD, 4'hC, 1'b1, 1'b0, 1'b0, 16'h0);
    slot(2'd2, 4'hC, 4'hB, 1'b1, 1'b0, 1'b0, 16'h0);
    digit_mask = 4'b0101;
    slot(2'd3, 4'hB, 4'hA, 1'b1, 1'b0, 1'b0, 16'h0);

    // Frame 4: digits 1 and 3 masked, full slots kept, nibble still updated.
    slot(2'd0, 4'hA, 4'hD, 1'b1, 1'b1, 1'b0, 16'h0);
    slot(2'd1, 4'hD, 4'hC, 1'b0, 1'b0, 1'b0, 16'h0);
    slot(2'd2, 4'hC, 4'hB, 1'b1, 1'b0, 1'b0, 16'h0);
    digit_mask = 4'hF;
    data_in    = 16'h4321;
    slot(2'd3, 4'hB, 4'hA, 1'b0, 1'b0, 1'b0, 16'h0);

    // Frame 5: en dropped during digit 2's dwell.
    slot(2'd0, 4'hA, 4'h1, 1'b1, 1'b1, 1'b0, 16'h0);
    slot(2'd1, 4'h1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0);
    step(2'd2, 1'b1, 4'h2, 1'b0);
    step(2'd2, 1'b1, 4'h2, 1'b0);
    step(2'd2, 1'b0, 4'h3, 1'b0);
    step(2'd2, 1'b0, 4'h3, 1'b0);
    en      = 1'b0;
    data_in = 16'h8765;
    repeat (3) step(2'd0, 1'b1, 4'h3, 1'b0);
    en = 1'b1;

    // Re-enabled frame, then a one-cycle reset during digit 3's blank gap.
    slot(2'd0, 4'h3, 4'h5, 1'b1, 1'b0, 1'b0, 16'h0);
    slot(2'd1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0, 16'h0);
    slot(2'd2, 4'h6, 4'h7, 1'b1, 1'b0, 1'b0, 16'h0);
    step(2'd3, 1'b1, 4'h7, 1'b0);
    rst = 1'b1;
    step(2'd0, 1'b1, 4'h0, 1'b0);
    rst = 1'b0;
    slot(2'd0, 4'h0, 4'h5, 1'b1, 1'b0, 1'b0, 16'h0);
    slot(2'd1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0, 16'h0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
